// File: rtl/scntr_capcmp_c.sv
// Capture/compare companion for an external counter: wrap counting, triggered capture with IRQ handshake, and compare-match pulse.
// Define SCNTR_CAPCMP_CAPT_SYNC_EN to pass CAPT through a two-flop synchronizer before edge detection.
module scntr_capcmp_c #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [N-1:0] Q,
    input  logic         COUT,
    input  logic [N-1:0] CMPV,
    input  logic         CMPLD,
    input  logic         ARM,
    input  logic         CAPT,
    input  logic         ACK,
    output logic         MATCH,
    output logic [N-1:0] CAPV,
    output logic [W-1:0] CAPW,
    output logic         IRQ,
    output logic         LOST,
    output logic         WSAT,
    output logic         BUSY
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_CAPTURED = 2'd2;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (v == {W{1'b1}})
            return v;
        return v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]   state;
    logic [W-1:0] wcnt;
    logic [W-1:0] wcnt_inc;
    logic         wcnt_max;
    logic         capt_edge;
    logic [N-1:0] cmp_reg;
    logic         eq_p0;
    logic         eq_p1;
    logic         cmpld_p1;

    // Stage p0 -> p1: CAPT edge detection (optionally behind a synchronizer)
`ifdef SCNTR_CAPCMP_CAPT_SYNC_EN
    logic capt_s1;
    logic capt_s2;
    logic capt_p1;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            capt_s1 <= 1'b0;
            capt_s2 <= 1'b0;
            capt_p1 <= 1'b0;
        end else begin
            capt_s1 <= CAPT;
            capt_s2 <= capt_s1;
            capt_p1 <= capt_s2;
        end
    end

    assign capt_edge = capt_s2 & ~capt_p1;
`else
    logic capt_p1;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            capt_p1 <= 1'b0;
        else
            capt_p1 <= CAPT;
    end

    assign capt_edge = CAPT & ~capt_p1;
`endif

    assign wcnt_inc = sat_inc(wcnt);
    assign wcnt_max = (wcnt == {W{1'b1}});

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= S_IDLE;
            wcnt  <= '0;
            CAPV  <= '0;
            CAPW  <= '0;
            LOST  <= 1'b0;
            WSAT  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ARM) begin
                        state <= S_ARMED;
                        wcnt  <= '0;
                        WSAT  <= 1'b0;
                        LOST  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (COUT) begin
                        wcnt <= wcnt_inc;
                        if (wcnt_max)
                            WSAT <= 1'b1;
                    end
                    // A wrap coinciding with the trigger is counted in the captured value
                    if (capt_edge) begin
                        CAPV  <= Q;
                        CAPW  <= COUT ? wcnt_inc : wcnt;
                        state <= S_CAPTURED;
                    end
                end
                S_CAPTURED: begin
                    if (capt_edge)
                        LOST <= 1'b1;
                    if (ACK)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign IRQ  = (state == S_CAPTURED);
    assign BUSY = (state == S_ARMED);

    // Stage p0 -> p1: compare, pulse only on a fresh equality or a fresh compare load
    assign eq_p0 = (Q == cmp_reg);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cmp_reg  <= '0;
            eq_p1    <= 1'b0;
            cmpld_p1 <= 1'b0;
            MATCH    <= 1'b0;
        end else begin
            if (CMPLD)
                cmp_reg <= CMPV;
            eq_p1    <= eq_p0;
            cmpld_p1 <= CMPLD;
            MATCH    <= eq_p0 & (~eq_p1 | cmpld_p1);
        end
    end

endmodule

// File: tb/tb_scntr_capcmp_c.sv
// Self-checking bench for scntr_capcmp_c: capture/IRQ handshake, wrap saturation, lost trigger, compare match and reset.
module tb_scntr_capcmp_c;

    localparam int N = 8;
    localparam int W = 4;

    typedef struct packed {
        logic [N-1:0] v;
        logic [W-1:0] w;
    } cap_t;

    logic         CLK = 1'b0;
    logic         CLR = 1'b0;
    logic [N-1:0] Q = 8'h33;
    logic         COUT = 1'b0;
    logic [N-1:0] CMPV = '0;
    logic         CMPLD = 1'b0;
    logic         ARM = 1'b0;
    logic         CAPT = 1'b0;
    logic         ACK = 1'b0;
    logic         MATCH;
    logic [N-1:0] CAPV;
    logic [W-1:0] CAPW;
    logic         IRQ;
    logic         LOST;
    logic         WSAT;
    logic         BUSY;

    int   total = 0;
    int   bad = 0;
    cap_t cap_q[$];
    logic match_q[$];
    cap_t exp_c;
    logic exp_m;

    scntr_capcmp_c #(.N(N), .W(W)) dut (
        .CLK(CLK), .CLR(CLR), .Q(Q), .COUT(COUT), .CMPV(CMPV), .CMPLD(CMPLD),
        .ARM(ARM), .CAPT(CAPT), .ACK(ACK), .MATCH(MATCH), .CAPV(CAPV),
        .CAPW(CAPW), .IRQ(IRQ), .LOST(LOST), .WSAT(WSAT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic capt_pulse();
        CAPT = 1'b1;
        tick();
`ifdef SCNTR_CAPCMP_CAPT_SYNC_EN
        tick();
        tick();
`endif
        CAPT = 1'b0;
        tick();
`ifdef SCNTR_CAPCMP_CAPT_SYNC_EN
        tick();
        tick();
`endif
    endtask

    task automatic cout_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            COUT = 1'b1;
            tick();
            COUT = 1'b0;
            tick();
        end
    endtask

    task automatic do_arm();
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({MATCH, CAPV, CAPW, IRQ, LOST, WSAT, BUSY} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {MATCH, CAPV, CAPW, IRQ, LOST, WSAT, BUSY});
        end
        tick();
        tick();
        CLR = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_arm();
        total++;
        if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", BUSY); end
        cout_pulses(3);
        Q = 8'h5A;
        cap_q.push_back('{v: 8'h5A, w: 4'd3});
        capt_pulse();
        exp_c = cap_q.pop_front();
        total++;
        if (CAPV !== exp_c.v) begin bad++; $display("FAIL basic_capv: got %0h want %0h", CAPV, exp_c.v); end
        total++;
        if (CAPW !== exp_c.w) begin bad++; $display("FAIL basic_capw: got %0d want %0d", CAPW, exp_c.w); end
        total++;
        if ({IRQ, BUSY} !== 2'b10) begin bad++; $display("FAIL basic_irq_busy: got %b want 10", {IRQ, BUSY}); end
        do_ack();
        total++;
        if ({IRQ, BUSY} !== 2'b00) begin bad++; $display("FAIL basic_ack_idle: got %b want 00", {IRQ, BUSY}); end
    endtask

    task automatic test_wsat();
        do_arm();
        for (int i = 0; i < 15; i++) begin
            COUT = 1'b1;
            tick();
        end
        total++;
        if (WSAT !== 1'b0) begin bad++; $display("FAIL wsat_at15: got %b want 0", WSAT); end
        tick();
        COUT = 1'b0;
        total++;
        if (WSAT !== 1'b1) begin bad++; $display("FAIL wsat_at16: got %b want 1", WSAT); end
        Q = 8'h3C;
        cap_q.push_back('{v: 8'h3C, w: 4'd15});
        capt_pulse();
        exp_c = cap_q.pop_front();
        total++;
        if (CAPW !== exp_c.w) begin bad++; $display("FAIL wsat_capw: got %0d want %0d", CAPW, exp_c.w); end
        do_ack();
        total++;
        if (WSAT !== 1'b1) begin bad++; $display("FAIL wsat_after_ack: got %b want 1", WSAT); end
        do_arm();
        total++;
        if (WSAT !== 1'b0) begin bad++; $display("FAIL wsat_rearm: got %b want 0", WSAT); end
        capt_pulse();
        do_ack();
    endtask

    task automatic test_lost();
        do_arm();
        cout_pulses(2);
        Q = 8'hA5;
        cap_q.push_back('{v: 8'hA5, w: 4'd2});
        capt_pulse();
        total++;
        if (LOST !== 1'b0) begin bad++; $display("FAIL lost_first: got %b want 0", LOST); end
        Q = 8'h11;
        capt_pulse();
        exp_c = cap_q.pop_front();
        total++;
        if (LOST !== 1'b1) begin bad++; $display("FAIL lost_second: got %b want 1", LOST); end
        total++;
        if ({CAPV, CAPW} !== {exp_c.v, exp_c.w}) begin
            bad++;
            $display("FAIL lost_keep_cap: got %0h/%0d want %0h/%0d", CAPV, CAPW, exp_c.v, exp_c.w);
        end
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        total++;
        if ({IRQ, BUSY, LOST} !== 3'b101) begin bad++; $display("FAIL lost_arm_ignored: got %b want 101", {IRQ, BUSY, LOST}); end
        do_ack();
        total++;
        if (LOST !== 1'b1) begin bad++; $display("FAIL lost_after_ack: got %b want 1", LOST); end
    endtask

    task automatic test_same_cycle();
        do_arm();
        total++;
        if (LOST !== 1'b0) begin bad++; $display("FAIL same_arm_clears_lost: got %b want 0", LOST); end
        do_ack();
        total++;
        if (BUSY !== 1'b1) begin bad++; $display("FAIL same_ack_ignored: got %b want 1", BUSY); end
        cout_pulses(2);
        Q = 8'h77;
        cap_q.push_back('{v: 8'h77, w: 4'd3});
        CAPT = 1'b1;
`ifdef SCNTR_CAPCMP_CAPT_SYNC_EN
        tick();
        tick();
`endif
        COUT = 1'b1;
        tick();
        COUT = 1'b0;
        CAPT = 1'b0;
        tick();
`ifdef SCNTR_CAPCMP_CAPT_SYNC_EN
        tick();
        tick();
`endif
        exp_c = cap_q.pop_front();
        total++;
        if ({CAPV, CAPW} !== {exp_c.v, exp_c.w}) begin
            bad++;
            $display("FAIL same_cycle_cap: got %0h/%0d want %0h/%0d", CAPV, CAPW, exp_c.v, exp_c.w);
        end
        do_ack();
    endtask

    task automatic test_match();
        int pulses;
        logic [N-1:0] steps [5];
        steps = '{8'h0F, 8'h10, 8'h10, 8'h11, 8'h11};
        pulses = 0;
        Q = 8'h0F;
        CMPV = 8'h10;
        CMPLD = 1'b1;
        tick();
        CMPLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Q = steps[i];
            match_q.push_back(i == 1);
            tick();
            exp_m = match_q.pop_front();
            if (MATCH === 1'b1) pulses++;
            total++;
            if (MATCH !== exp_m) begin bad++; $display("FAIL match_step%0d: got %b want %b", i, MATCH, exp_m); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL match_count: got %0d want 1", pulses); end
    endtask

    task automatic test_clr();
        Q = 8'h22;
        do_arm();
        cout_pulses(1);
        #2;
        CLR = 1'b0;
        #1;
        total++;
        if ({MATCH, CAPV, CAPW, IRQ, LOST, WSAT, BUSY} !== '0) begin
            bad++;
            $display("FAIL clr_mid_armed: got %0h want 0", {MATCH, CAPV, CAPW, IRQ, LOST, WSAT, BUSY});
        end
        tick();
        CLR = 1'b1;
        tick();
        capt_pulse();
        tick();
        total++;
        if ({IRQ, BUSY, CAPV} !== '0) begin bad++; $display("FAIL clr_no_irq: got %0h want 0", {IRQ, BUSY, CAPV}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wsat();
        test_lost();
        test_same_cycle();
        test_match();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
